audio_pcm: RTL and testbench

- Downstream stage of the audio mixer. Consumes the 10-bit unsigned mix word and produces 16-bit signed PCM samples at a fixed, clock-divided sample rate.
- Each sample passes through a DC-blocking high-pass filter with output saturation.
- Samples are presented to the platform audio sink over a valid/ready handshake.

---
 rtl/audio_pcm_pkg.sv | 34 +++
 rtl/audio_pcm_dcblock.sv | 51 +++++
 rtl/audio_pcm.sv | 154 +++++++++++++++
 tb/tb_audio_pcm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared types, widths and the PCM saturation helper for the
//             audio_pcm output stage.
//  Revision : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int PCM_W   = 16;
    localparam int MIX_W   = 10;
    localparam int PCM_MAX = 32767;
    localparam int PCM_MIN = -32768;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        FILTER  = 2'd2,
        PRESENT = 2'd3
    } state_e;

    // Clamp a wide signed intermediate into the 16-bit PCM range.
    function automatic logic signed [PCM_W-1:0] saturate(input logic signed [31:0] v);
        if (v > PCM_MAX) begin
            return 16'sh7FFF;
        end else if (v < PCM_MIN) begin
            return 16'sh8000;
        end else begin
            return v[PCM_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_pcm_dcblock.sv
`default_nettype none
// ============================================================================
//  Module   : audio_dcblock
//  Purpose  : Leaky-integrator DC blocker. y_sat = sat(x - (acc >>> SHIFT)),
//             computed combinationally; acc accumulates y_sat when en=1.
//  Revision : 1.0  initial release
// ============================================================================
module audio_dcblock
    import audio_pkg::*;
#(
    // Intermediates are 32 bits wide, so DCB_SHIFT must stay <= 15.
    parameter int DCB_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [PCM_W-1:0] x,
    output logic signed [PCM_W-1:0] y_sat
);

    localparam int ACC_W = PCM_W + DCB_SHIFT + 1;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [31:0]      acc_ext;
    logic signed [31:0]      dc;
    logic signed [31:0]      diff;

    // Subtract the leaked DC estimate, saturate, and fold the result back into acc.
    always_comb begin
        acc_ext = 32'(acc_q);
        dc      = acc_ext >>> DCB_SHIFT;
        diff    = 32'(x) - dc;
        y_sat   = saturate(diff);
        acc_d   = acc_q;
        if (en) begin
            acc_d = acc_q + ACC_W'(y_sat);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_pcm.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pcm
//  Purpose  : Converts the 10-bit unsigned mix word into 16-bit signed PCM at
//             a clock-divided sample rate, DC-blocks it, and presents it on a
//             valid/ready handshake with a sticky overrun flag.
//  Options  : AUDIO_SDM_EN adds a first-order sigma-delta 1-bit output (sdm).
//  Revision : 1.0  initial release
// ============================================================================
module audio_pcm
    import audio_pkg::*;
#(
    parameter int CLOCK_DIV = 146,
    parameter int DCB_SHIFT = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [MIX_W-1:0] d,
    input  logic             mute,
    output logic [PCM_W-1:0] pcm,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
`ifdef AUDIO_SDM_EN
    ,
    output logic             sdm
`endif
);

    localparam int CNT_W = 16;

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    tick;

    state_e                  state_q;
    state_e                  state_d;
    logic signed [PCM_W-1:0] x_q;
    logic signed [PCM_W-1:0] x_d;
    logic signed [PCM_W-1:0] y_q;
    logic signed [PCM_W-1:0] y_d;
    logic signed [PCM_W-1:0] y_sat;
    logic [PCM_W-1:0]        pcm_q;
    logic [PCM_W-1:0]        pcm_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    overrun_q;
    logic                    overrun_d;

    // Free-running sample-rate divider; runs regardless of FSM or sink.
    always_comb begin
        tick  = (cnt_q == CNT_W'(CLOCK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Sample pipeline: WAIT -> CAPTURE -> FILTER -> PRESENT, plus handshake.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        pcm_d     = pcm_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            WAIT: begin
                if (tick) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Offset binary to two's complement: mid-scale 512 maps to 0.
                x_d     = mute ? '0 : ({d, {(PCM_W - MIX_W){1'b0}}} ^ 16'h8000);
                state_d = FILTER;
            end
            FILTER: begin
                y_d     = y_sat;
                state_d = PRESENT;
            end
            PRESENT: begin
                pcm_d   = y_q;
                valid_d = 1'b1;
                // A same-cycle accept drains the old sample, so only a stalled sink overruns.
                if (valid_q && !ready) begin
                    overrun_d = 1'b1;
                end
                state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            state_q   <= WAIT;
            x_q       <= '0;
            y_q       <= '0;
            pcm_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pcm_q     <= pcm_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    audio_dcblock #(
        .DCB_SHIFT (DCB_SHIFT)
    ) u_dcblock (
        .clk   (clock),
        .rst_n (reset),
        .en    (state_q == FILTER),
        .x     (x_q),
        .y_sat (y_sat)
    );

    assign pcm     = pcm_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

`ifdef AUDIO_SDM_EN
    logic [PCM_W:0] acc17_q;
    logic [PCM_W:0] acc17_d;

    // First-order sigma-delta on the offset-binary PCM; the carry is the bitstream.
    always_comb begin
        acc17_d = {1'b0, acc17_q[PCM_W-1:0]} + {1'b0, pcm_q ^ 16'h8000};
    end

    // Sigma-delta accumulator register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc17_q <= '0;
        end else begin
            acc17_q <= acc17_d;
        end
    end

    assign sdm = acc17_q[PCM_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_pcm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_audio_pcm
//  Purpose  : Directed self-checking bench for audio_pcm. A default-rate
//             instance covers reset, latency, handshake and overrun; a fast
//             instance (CLOCK_DIV=8) covers filter decay and saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_pcm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-rate instance
    logic        rst_n_s;
    logic [9:0]  d_s;
    logic        mute_s;
    logic        ready_s;
    logic [15:0] pcm_s;
    logic        valid_s;
    logic        overrun_s;
    // Fast instance
    logic        rst_n_f;
    logic [9:0]  d_f;
    logic        mute_f;
    logic        ready_f;
    logic [15:0] pcm_f;
    logic        valid_f;
    logic        overrun_f;
`ifdef AUDIO_SDM_EN
    logic        sdm_s;
    logic        sdm_f;
`endif

    int checks = 0;
    int errors = 0;

    audio_pcm u_slow (
        .clock   (clk),
        .reset   (rst_n_s),
        .d       (d_s),
        .mute    (mute_s),
        .pcm     (pcm_s),
        .valid   (valid_s),
        .ready   (ready_s),
        .overrun (overrun_s)
`ifdef AUDIO_SDM_EN
        ,
        .sdm     (sdm_s)
`endif
    );

    audio_pcm #(
        .CLOCK_DIV (8),
        .DCB_SHIFT (10)
    ) u_fast (
        .clock   (clk),
        .reset   (rst_n_f),
        .d       (d_f),
        .mute    (mute_f),
        .pcm     (pcm_f),
        .valid   (valid_f),
        .ready   (ready_f),
        .overrun (overrun_f)
`ifdef AUDIO_SDM_EN
        ,
        .sdm     (sdm_f)
`endif
    );

    // Count rising edges until valid_s is seen high (#1 after the edge).
    task automatic wait_rise_s(input int bound, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < bound && !ok) begin
            @(posedge clk);
            n++;
            #1;
            if (valid_s) ok = 1'b1;
        end
    endtask

    // Fetch the next sample from the fast instance (ready_f held high).
    task automatic get_fast(output logic [15:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (valid_f) begin
                ok = 1'b1;
                v  = pcm_f;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        rst_n_s = 1'b0;
        d_s     = 10'd512;
        mute_s  = 1'b0;
        ready_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pcm_s !== 16'h0000) begin errors++; $display("FAIL reset_pcm: got %h expected 0000", pcm_s); end
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_s); end
        checks++; if (overrun_s !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_s); end
        @(negedge clk);
        rst_n_s = 1'b1;
        wait_rise_s(400, n, ok);
        checks++; if (!ok || n != 149) begin errors++; $display("FAIL first_valid_latency: got %0d edges (seen=%0d) expected 149", n, ok); end
        checks++; if (pcm_s !== 16'h0000) begin errors++; $display("FAIL first_sample_mid: got %h expected 0000", pcm_s); end
    endtask

    task automatic test_zero_stream();
        int n;
        bit ok;
        @(posedge clk);
        #1;
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL valid_clear_after_accept: got %b expected 0", valid_s); end
        for (int k = 0; k < 2; k++) begin
            wait_rise_s(400, n, ok);
            checks++; if (!ok || n != 145) begin errors++; $display("FAIL sample_spacing: got %0d edges expected 145", n); end
            checks++; if (pcm_s !== 16'h0000) begin errors++; $display("FAIL zero_stream_pcm: got %h expected 0000", pcm_s); end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef AUDIO_SDM_EN
    task automatic test_sdm();
        int ones;
        ones = 0;
        repeat (1024) begin
            @(posedge clk);
            #1;
            ones += int'(sdm_s);
        end
        checks++; if (ones < 511 || ones > 513) begin errors++; $display("FAIL sdm_duty: got %0d ones expected 512+-1", ones); end
    endtask
`endif

    task automatic test_overrun_and_reset();
        int n;
        bit ok;
        // Align to a fresh sample, then stall the sink.
        for (int i = 0; i < 400 && valid_s; i++) begin @(posedge clk); #1; end
        wait_rise_s(400, n, ok);
        @(posedge clk);
        #1;
        ready_s = 1'b0;
        d_s     = 10'd1023;
        wait_rise_s(400, n, ok);
        checks++; if (!ok || pcm_s !== 16'h7FC0) begin errors++; $display("FAIL step_first_sample: got %h expected 7fc0", pcm_s); end
        checks++; if (overrun_s !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun_s); end
        repeat (145) @(posedge clk);
        #1;
        checks++; if (valid_s !== 1'b1 || pcm_s !== 16'h7FC0) begin errors++; $display("FAIL hold_while_stalled: got valid=%b pcm=%h expected 1/7fc0", valid_s, pcm_s); end
        @(posedge clk);
        #1;
        checks++; if (pcm_s !== 16'h7FA1) begin errors++; $display("FAIL overwrite_pcm: got %h expected 7fa1", pcm_s); end
        checks++; if (valid_s !== 1'b1) begin errors++; $display("FAIL overwrite_valid: got %b expected 1", valid_s); end
        checks++; if (overrun_s !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun_s); end
        // Reset while the next sample is in FILTER.
        repeat (144) @(posedge clk);
        #2;
        rst_n_s = 1'b0;
        #1;
        checks++; if (pcm_s !== 16'h0000 || valid_s !== 1'b0 || overrun_s !== 1'b0) begin
            errors++; $display("FAIL async_reset: got pcm=%h valid=%b overrun=%b expected 0000/0/0", pcm_s, valid_s, overrun_s);
        end
        @(negedge clk);
        rst_n_s = 1'b1;
        wait_rise_s(400, n, ok);
        checks++; if (!ok || n != 149) begin errors++; $display("FAIL latency_after_reset: got %0d edges expected 149", n); end
        checks++; if (pcm_s !== 16'h7FC0) begin errors++; $display("FAIL sample_after_reset: got %h expected 7fc0", pcm_s); end
        // Sink accepts in the PRESENT cycle: no overrun.
        repeat (145) @(posedge clk);
        #1;
        ready_s = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (pcm_s !== 16'h7FA1 || valid_s !== 1'b1) begin errors++; $display("FAIL present_accept: got pcm=%h valid=%b expected 7fa1/1", pcm_s, valid_s); end
        checks++; if (overrun_s !== 1'b0) begin errors++; $display("FAIL no_overrun_on_accept: got %b expected 0", overrun_s); end
        @(posedge clk);
        #1;
        checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL valid_clear: got %b expected 0", valid_s); end
        // Mute: x=0, acc=65377 -> dc=63 -> y=-63.
        mute_s = 1'b1;
        wait_rise_s(400, n, ok);
        checks++; if (!ok || pcm_s !== 16'hFFC1) begin errors++; $display("FAIL mute_sample: got %h expected ffc1", pcm_s); end
        mute_s = 1'b0;
    endtask

    task automatic test_decay();
        logic [15:0] v;
        logic signed [15:0] prev;
        logic signed [15:0] cur;
        bit ok;
        bit mono_ok;
        logic [15:0] head [4];
        head[0] = 16'd32704; head[1] = 16'd32673; head[2] = 16'd32641; head[3] = 16'd32609;
        rst_n_f = 1'b0; d_f = 10'd512; mute_f = 1'b0; ready_f = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_f = 1'b1;
        for (int i = 0; i < 3; i++) get_fast(v, ok);
        checks++; if (!ok || v !== 16'h0000) begin errors++; $display("FAIL fast_mid_sample: got %h expected 0000", v); end
        d_f = 10'd1023;
        for (int i = 0; i < 4; i++) begin
            get_fast(v, ok);
            checks++; if (!ok || v !== head[i]) begin errors++; $display("FAIL decay_head_%0d: got %0d expected %0d", i, v, head[i]); end
        end
        prev    = $signed(v);
        cur     = prev;
        mono_ok = 1'b1;
        for (int i = 4; i <= 4096 && ok; i++) begin
            get_fast(v, ok);
            cur = $signed(v);
            if (cur > prev) mono_ok = 1'b0;
            prev = cur;
        end
        checks++; if (!ok || !mono_ok) begin errors++; $display("FAIL decay_monotonic: got seen=%0d mono=%0d expected 1/1", ok, mono_ok); end
        checks++; if (cur >= 16'sd600 || cur <= -16'sd600) begin errors++; $display("FAIL decay_settled: got %0d expected |pcm|<600", cur); end
        // Negative step from a large positive DC estimate clamps to -32768.
        d_f = 10'd0;
        get_fast(v, ok);
        checks++; if (!ok || v !== 16'h8000) begin errors++; $display("FAIL neg_saturate: got %h expected 8000", v); end
    endtask

    task automatic test_saturation();
        logic [15:0] v;
        bit ok;
        rst_n_f = 1'b0; d_f = 10'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_f = 1'b1;
        get_fast(v, ok);
        checks++; if (!ok || v !== 16'h8000) begin errors++; $display("FAIL d0_first_sample: got %h expected 8000", v); end
        for (int i = 0; i < 63 && ok; i++) get_fast(v, ok);
        d_f = 10'd1023;
        get_fast(v, ok);
        checks++; if (!ok || v !== 16'h7FFF) begin errors++; $display("FAIL pos_saturate: got %h expected 7fff", v); end
    endtask

    initial begin
        rst_n_f = 1'b0; d_f = 10'd512; mute_f = 1'b0; ready_f = 1'b1;
        test_reset();
        test_zero_stream();
`ifdef AUDIO_SDM_EN
        test_sdm();
`endif
        test_overrun_and_reset();
        test_decay();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
